addsub_serial: RTL and testbench
================================

Name: addsub_serial

Overview:
Parametrised, digit-serial two's-complement adder/subtractor with a start/done handshake.
- Processes DIGIT bits per clock, LSB digit first, using a DIGIT-bit ripple adder slice and a registered carry.
- Trades latency for area in wide datapaths.
- Successor to the team's fixed 4-bit combinational add/sub cell. Adds width/digit generality, a signed-overflow flag and sequencing.
- Sits between operand registers and an accumulator/ALU result bus.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- DIGIT, 2, bits processed per cycle; must divide WIDTH, 1 <= DIGIT <= WIDTH. Violation is an elaboration-time error.
- Derived NDIG = WIDTH/DIGIT, the number of RUN cycles.

Ports:
- clk, input, 1, sole clock; all state changes on its rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request; sampled only in IDLE.
- a, input, WIDTH, minuend/augend; captured when start is accepted.
- b, input, WIDTH, subtrahend/addend; captured when start is accepted.
- sel, input, 1, mode: 0 = a+b, 1 = a-b; captured when start is accepted.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, single-cycle pulse; result valid.
- r, output, WIDTH, result.
- cb, output, 1, carry-out of a + (b^{sel}) + sel. For subtract, 1 = no borrow.
- ovf, output, 1, signed two's-complement overflow.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - busy, done, r, cb and ovf all 0.
  - Internal operand, carry and count registers cleared.
  - rst dominates start.
- IDLE:
  - start=1 at an edge captures a, b^{WIDTH{sel}} and sel. Carry register loads sel.
  - Digit counter loads 0; state moves to RUN.
  - start=0: remain in IDLE.
- RUN:
  - Each edge adds the current DIGIT-bit digit of a, the current digit of the modified b, and the carry.
  - It stores the DIGIT sum bits into the result shift register, updates the carry, shifts the operands by DIGIT and increments the counter.
  - After NDIG edges, move to DONE.
- DONE:
  - r, cb and ovf are loaded at the edge entering DONE.
  - done=1 for exactly that one cycle; the next edge returns to IDLE.
- Latency: start high in cycle T means done is high in cycle T+NDIG+1. With defaults, done is high in T+5.
- Throughput: one operation per NDIG+2 cycles.
- Output hold: r, cb and ovf keep their value from DONE until the next DONE or reset. They do not change during RUN; intermediate sums stay internal.
- start while busy is ignored; no queuing. start in the DONE cycle is also ignored.
- Carry/flag rules:
  - cb is the final carry from the MSB digit.
  - ovf = (a[MSB] == bmod[MSB]) && (sum[MSB] != a[MSB]), where bmod = b^{sel}.
- Wrap-around: r is the sum modulo 2^WIDTH. The block never stalls on overflow.
- DIGIT=WIDTH degenerates to a single RUN cycle; latency T+2.
- Reset mid-RUN: the operation is aborted, no done pulse, outputs zero. The next start behaves normally.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when ovf=1, r saturates. Positive overflow (a[MSB]=0) gives 0 followed by WIDTH-1 ones. Negative overflow gives 1 followed by WIDTH-1 zeros. cb and ovf are still reported from the raw sum. Latency is unchanged.
- Undefined: r is always the wrapped sum; no saturation logic is present.

Test Plan:
1. Add, defaults (WIDTH=8, DIGIT=2): a=0x3C, b=0x15, sel=0, start in cycle T -> done only in T+5, r=0x51, cb=0, ovf=0; busy high T+1..T+5.
2. Subtract with borrow: a=0x15, b=0x3C, sel=1 -> r=0xD9, cb=0, ovf=0. Then a=0xFF, b=0x01, sel=0 -> r=0x00, cb=1, ovf=0.
3. Positive overflow: a=0x70, b=0x20, sel=0 -> r=0x90, cb=0, ovf=1. With ADDSUB_SAT_EN: r=0x7F, cb=0, ovf=1.
4. Negative overflow: a=0x80, b=0x01, sel=1 -> r=0x7F, cb=1, ovf=1. With ADDSUB_SAT_EN: r=0x80.
5. Handshake/reset: start held high continuously -> done every 6 cycles, operands resampled only in IDLE. rst asserted in the second RUN cycle -> outputs 0, no done pulse; the following start yields the correct result.
6. Parameter sweep WIDTH in {4,8,16}, DIGIT in {1,WIDTH/2,WIDTH}, random a/b/sel, ≥1000 ops each -> r/cb/ovf match the reference model, latency exactly NDIG+1 cycles after the start cycle.

Source files
------------

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/sub: DIGIT bits per cycle, LSB first; optional saturation via ADDSUB_SAT_EN.
// Latency: start in cycle T gives done in cycle T+NDIG+1; one operation per NDIG+2 cycles.
// Backpressure: none; start is only sampled in IDLE, and requests while busy or in DONE are dropped.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             cb,
    output logic             ovf
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_chk
        $error("addsub_serial: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb, bm_msb;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] r_nxt;
    logic             last;
    logic             ovf_nxt;

    // Sum bits enter at the top of acc, so after NDIG shifts the LSB digit sits at bit 0.
    always_comb begin
        dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        sum_nxt = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last    = (cnt == CW'(NDIG - 1));
        ovf_nxt = (a_msb == bm_msb) && (sum_nxt[WIDTH-1] != a_msb);
        r_nxt   = sum_nxt;
`ifdef ADDSUB_SAT_EN
        if (ovf_nxt) begin
            r_nxt = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            bm_msb <= 1'b0;
            r      <= '0;
            cb     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    // Subtract is a + ~b + 1: invert b here and seed the carry with sel.
                    a_sh   <= a;
                    b_sh   <= b ^ {WIDTH{sel}};
                    carry  <= sel;
                    cnt    <= '0;
                    acc    <= '0;
                    a_msb  <= a[WIDTH-1];
                    bm_msb <= b[WIDTH-1] ^ sel;
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    acc   <= sum_nxt;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        r   <= r_nxt;
                        cb  <= dsum[DIGIT];
                        ovf <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_addsub_serial.sv
// Directed and parameter-sweep bench for addsub_serial with a scoreboard of expected results.
module tb_addsub_serial;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] r;
        logic        cb;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, sel;
    logic [7:0] a, b, r;
    logic       busy, done, cb, ovf;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sel(sel),
        .busy(busy), .done(done), .r(r), .cb(cb), .ovf(ovf)
    );

    localparam int NSW = 9;
    localparam int SW_W [NSW] = '{4, 4, 4, 8, 8, 8, 16, 16, 16};
    localparam int SW_D [NSW] = '{1, 2, 4, 1, 4, 8, 1, 8, 16};

    logic [NSW-1:0]       sw_start, sw_sel, sw_busy, sw_done, sw_cb, sw_ovf;
    logic [NSW-1:0][15:0] sw_a, sw_b, sw_r;
    exp_t                 sw_exp [NSW];

    for (genvar k = 0; k < NSW; k++) begin : g_sw
        localparam int W = SW_W[k];
        localparam int D = SW_D[k];
        logic [W-1:0] rr;
        addsub_serial #(.WIDTH(W), .DIGIT(D)) u (
            .clk(clk), .rst(rst), .start(sw_start[k]), .a(sw_a[k][W-1:0]), .b(sw_b[k][W-1:0]),
            .sel(sw_sel[k]), .busy(sw_busy[k]), .done(sw_done[k]), .r(rr), .cb(sw_cb[k]), .ovf(sw_ovf[k])
        );
        assign sw_r[k] = 16'(rr);
    end

    exp_t       sbq [$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_r = 8'h00;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, expv);
        end
    endtask

    function automatic exp_t model(input int w, input logic [15:0] ia, input logic [15:0] ib, input logic isel);
        logic [16:0] full;
        logic [15:0] mask, bm, rr;
        exp_t        e;
        mask  = 16'((17'd1 << w) - 17'd1);
        bm    = (isel ? ~ib : ib) & mask;
        full  = {1'b0, ia & mask} + {1'b0, bm} + 17'(isel);
        rr    = full[15:0] & mask;
        e.cb  = full[w];
        e.ovf = (ia[w-1] == bm[w-1]) && (rr[w-1] != ia[w-1]);
        if (SAT && e.ovf) rr = ia[w-1] ? (16'd1 << (w - 1)) : (mask >> 1);
        e.r = rr;
        return e;
    endfunction

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 0, 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, "_r"}, 0, 32'(r), 32'(e.r[7:0]));
            chk({tag, "_cb"}, 0, 32'(cb), 32'(e.cb));
            chk({tag, "_ovf"}, 0, 32'(ovf), 32'(e.ovf));
        end
    endtask

    // One operation on the default instance: start in cycle T, done expected only in T+5.
    task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib, input logic isel,
                         input logic [7:0] er, input logic ecb, input logic eovf);
        exp_t e;
        e.r = 16'(er); e.cb = ecb; e.ovf = eovf;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; sel = isel;
        sbq.push_back(e);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            chk({tag, "_busy"}, c, 32'(busy), 32'(c <= 5));
            chk({tag, "_done"}, c, 32'(done), 32'(c == 5));
            if (c < 5) chk({tag, "_hold_r"}, c, 32'(r), 32'(last_r));
            if (c == 5) pop_cmp(tag);
        end
        last_r = er;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; sel = 1'b0;
        sw_start = '0; sw_sel = '0; sw_a = '0; sw_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_r", 0, 32'(r), 32'd0);
        chk("rst_cb", 0, 32'(cb), 32'd0);
        chk("rst_ovf", 0, 32'(ovf), 32'd0);
        start = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 0, 32'(busy), 32'd0);

        do_op("add", 8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0);
        do_op("sub_borrow", 8'h15, 8'h3C, 1'b1, 8'hD9, 1'b0, 1'b0);
        do_op("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("pos_ovf", 8'h70, 8'h20, 1'b0, SAT ? 8'h7F : 8'h90, 1'b0, 1'b1);
        do_op("neg_ovf", 8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1);

        // start held high: operands changed while busy or in DONE must not be picked up.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02; sel = 1'b0;
        sbq.push_back('{r: 16'h0003, cb: 1'b0, ovf: 1'b0});
        sbq.push_back('{r: 16'h0025, cb: 1'b0, ovf: 1'b0});
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) begin a = 8'h10; b = 8'h10; end
            if (c == 5) a = 8'h40;
            if (c == 6) begin a = 8'h20; b = 8'h05; end
            if (c == 7) start = 1'b0;
            chk("held_done", c, 32'(done), 32'(c == 5 || c == 11));
            chk("held_busy", c, 32'(busy), 32'(c != 6 && c != 12));
            if (c == 5 || c == 11) pop_cmp("held");
        end
        last_r = 8'h25;

        // Reset in the second RUN cycle aborts with outputs cleared and no done pulse.
        @(negedge clk);
        start = 1'b1; a = 8'h70; b = 8'h20; sel = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            chk("abort_done", c, 32'(done), 32'd0);
            if (c <= 2) chk("abort_hold_r", c, 32'(r), 32'h25);
            if (c == 3) begin
                chk("abort_busy", c, 32'(busy), 32'd0);
                chk("abort_r", c, 32'(r), 32'd0);
                chk("abort_cb", c, 32'(cb), 32'd0);
                chk("abort_ovf", c, 32'(ovf), 32'd0);
            end
        end
        last_r = 8'h00;
        do_op("after_abort", 8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0);
        chk("sb_empty", 0, 32'(sbq.size()), 32'd0);

        // Sweep: all configurations started together; each checks exact latency and result.
        @(negedge clk);
        for (int op = 0; op < 1000; op++) begin
            for (int k = 0; k < NSW; k++) begin
                sw_a[k]   = 16'($urandom);
                sw_b[k]   = 16'($urandom);
                sw_sel[k] = 1'($urandom);
                sw_exp[k] = model(SW_W[k], sw_a[k], sw_b[k], sw_sel[k]);
            end
            sw_start = '1;
            for (int c = 1; c <= 18; c++) begin
                @(negedge clk);
                if (c == 1) sw_start = '0;
                for (int k = 0; k < NSW; k++) begin
                    int nd;
                    nd = SW_W[k] / SW_D[k];
                    if (c <= nd + 2) begin
                        chk("sw_done", k, 32'(sw_done[k]), 32'(c == nd + 1));
                        chk("sw_busy", k, 32'(sw_busy[k]), 32'(c <= nd + 1));
                    end
                    if (c == nd + 1) begin
                        chk("sw_r", k, 32'(sw_r[k]), 32'(sw_exp[k].r));
                        chk("sw_cb", k, 32'(sw_cb[k]), 32'(sw_exp[k].cb));
                        chk("sw_ovf", k, 32'(sw_ovf[k]), 32'(sw_exp[k].ovf));
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
